spi_txn_arbiter: RTL
====================

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 3, number of requesters; legal range 2..4.
REQ-002 Parameter: XFER_CYCLES, 8, number of clock cycles the SPI master needs to shift one byte.
REQ-003 Port: SCLK  in  1  block clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  NUM_REQ  per-requester transaction request, level; bit i belongs to requester i.
REQ-006 Port: req_data  in  8*NUM_REQ  byte to transmit; requester i uses bits [8i+7:8i].
REQ-007 Port: req_slave  in  2*NUM_REQ  target slave index; requester i uses bits [2i+1:2i].
REQ-008 Port: gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-009 Port: mst_start  out  1  start pulse to the SPI master.
REQ-010 Port: mst_slave_select  out  2  slave index to the SPI master.
REQ-011 Port: mst_tx_data  out  8  byte to the SPI master.
REQ-012 Port: mst_rx_data  in  8  byte received by the SPI master.
REQ-013 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-014 Port: rsp_id  out  2  index of the completed requester.
REQ-015 Port: rsp_data  out  8  received byte.
REQ-016 Port: rsp_err  out  1  completion carried an illegal slave index.
REQ-017 Port: busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states are IDLE, START, XFER and DONE, and the block shall never enter any other state.
REQ-019 IDLE: if any req bit is high, the block shall pick a winner, pulse gnt[winner], latch its req_data, req_slave and index, and go to START on the same edge.
REQ-020 Arbitration shall be round-robin: search starts at (last winner + 1) mod NUM_REQ, and the last-winner pointer shall update only on a grant.
REQ-021 START with a latched slave index of 0..2: mst_start=1 for exactly one cycle, the transfer counter shall clear to 0, and the next state shall be XFER.
REQ-022 START with a latched slave index of 3: the block shall not assert mst_start and shall go directly to DONE with rsp_err=1 and rsp_data=8'hFF.
REQ-023 XFER: the counter shall increment each cycle; when counter==XFER_CYCLES-1, the next state shall be DONE. The counter width shall be clog2(XFER_CYCLES)+1 and the counter shall never wrap.
REQ-024 mst_slave_select and mst_tx_data shall hold the latched values in START and XFER, and be 0 otherwise.
REQ-025 DONE: rsp_valid=1 for one cycle, rsp_data=mst_rx_data sampled in that cycle, rsp_id=latched index; the next state shall be IDLE.
REQ-026 Latency: with gnt at cycle N, rsp_valid shall be at cycle N+XFER_CYCLES+2 (N+2 on the error path). No new grant shall occur in START, XFER or DONE; back-to-back throughput is one transaction per XFER_CYCLES+3 cycles.
REQ-027 req bits are sampled only in IDLE: a requester that drops req before being granted is withdrawn, and changes to req_data or req_slave after gnt shall have no effect.
REQ-028 rsp_id, rsp_data and rsp_err shall hold their values until the next DONE; rsp_err shall be 0 on legal completions.

Reset
REQ-029 Reset shall force the state to IDLE, the counter to 0, gnt=0, mst_start=0, mst_slave_select=0, mst_tx_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, and the last-winner pointer to NUM_REQ-1 (so requester 0 wins first).
REQ-030 Reset asserted mid-transaction shall abort it without a response, and the first grant after release shall follow REQ-029 priority.

Configuration
REQ-031 Macro SPI_ARB_FIXED_PRIO_EN: when defined, arbitration shall be fixed-priority with the lowest index winning and the pointer unused; when undefined, arbitration shall be round-robin per REQ-020.

Verification
REQ-032 Reset, then req=3'b001, req_data[7:0]=8'hA5, req_slave[1:0]=1 -> gnt=001 at N, mst_start at N+1 with mst_slave_select=1 and mst_tx_data=A5; with mst_rx_data=8'h3C, rsp_valid at N+10 with rsp_id=0, rsp_data=3C, rsp_err=0.
REQ-033 req=3'b111 held continuously (round-robin) -> grant order 0,1,2,0, with successive gnt pulses 11 cycles apart.
REQ-034 req=3'b111 held continuously, SPI_ARB_FIXED_PRIO_EN defined -> every grant goes to requester 0.
REQ-035 Requester 2 with req_slave=3 -> gnt at N, no mst_start, rsp_valid at N+2 with rsp_err=1, rsp_data=FF, rsp_id=2.
REQ-036 Reset pulsed at counter=4 of XFER -> all outputs return to 0 immediately, no rsp_valid is issued, and busy=0.
REQ-037 req pulsed high, then dropped while another transaction is in XFER -> the withdrawn requester never receives gnt.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that serialises byte transactions from NUM_REQ requesters onto one SPI master.
// Define SPI_ARB_FIXED_PRIO_EN to switch to fixed priority, where the lowest index wins.
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int XFER_CYCLES = 8
) (
    input  logic                   SCLK,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [2*NUM_REQ-1:0]   req_slave,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   mst_start,
    output logic [1:0]             mst_slave_select,
    output logic [7:0]             mst_tx_data,
    input  logic [7:0]             mst_rx_data,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [7:0]             rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int CW = $clog2(XFER_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [1:0]      id_reg;
    logic            err_reg;

    logic [7:0]      data_arr  [4];
    logic [1:0]      slave_arr [4];
    logic [3:0]      req_ext;
    logic [3:0]      onehot;
    logic            found;
    logic [1:0]      winner;

    // Pad per-requester lanes to four so a 2-bit winner index always selects cleanly.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < NUM_REQ) begin : g_used
                assign data_arr[gi]  = req_data[8*gi +: 8];
                assign slave_arr[gi] = req_slave[2*gi +: 2];
            end else begin : g_pad
                assign data_arr[gi]  = 8'h00;
                assign slave_arr[gi] = 2'd0;
            end
        end
    endgenerate

    assign req_ext = 4'(req);
    assign onehot  = 4'b0001 << winner;

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_ext[2'(k)]) begin
                found  = 1'b1;
                winner = 2'(k);
            end
        end
    end
`else
    logic [1:0] last_reg;
    int         cand;

    // Search begins just past the previous winner and wraps once around.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(last_reg) + 1 + k;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            if (!found && req_ext[2'(cand)]) begin
                found  = 1'b1;
                winner = 2'(cand);
            end
        end
    end

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset)
            last_reg <= 2'(NUM_REQ - 1);
        else if (state_reg == IDLE && found)
            last_reg <= winner;
    end
`endif

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            id_reg           <= 2'd0;
            err_reg          <= 1'b0;
            gnt              <= '0;
            mst_start        <= 1'b0;
            mst_slave_select <= 2'd0;
            mst_tx_data      <= 8'h00;
            rsp_valid        <= 1'b0;
            rsp_id           <= 2'd0;
            rsp_data         <= 8'h00;
            rsp_err          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            gnt       <= '0;
            mst_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        gnt              <= onehot[NUM_REQ-1:0];
                        id_reg           <= winner;
                        err_reg          <= (slave_arr[winner] == 2'd3);
                        mst_slave_select <= slave_arr[winner];
                        mst_tx_data      <= data_arr[winner];
                        busy             <= 1'b1;
                        state_reg        <= START;
                    end
                end
                START: begin
                    if (err_reg) begin
                        mst_slave_select <= 2'd0;
                        mst_tx_data      <= 8'h00;
                        state_reg        <= DONE;
                    end else begin
                        mst_start <= 1'b1;
                        count_reg <= '0;
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(XFER_CYCLES - 1)) begin
                        mst_slave_select <= 2'd0;
                        mst_tx_data      <= 8'h00;
                        state_reg        <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_reg;
                    rsp_err   <= err_reg;
                    rsp_data  <= err_reg ? 8'hFF : mst_rx_data;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
